// File: rtl/adder_result_collector.sv
// adder_result_collector
// Captures the half-adder stage result, checks its sign-extension format,
// counts carries and dropped words, and buffers accepted words in a small
// first-word-fall-through FIFO for valid/ready readout.
// Optional feature: define RESULT_ACC_EN to build the running-sum accumulator;
// without it acc is tied to zero and no accumulator register exists.
module adder_result_collector #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [N-1:0]             out_data,
  input  logic                     out_ready,
  input  logic                     clr,
  output logic [CNT_W-1:0]         carry_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     fmt_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic [ACC_W-1:0]         acc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int HALF  = N / 2;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [N-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   carry_cnt_q, carry_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               fmt_err_q, fmt_err_d;

  logic               push;
  logic               pop;
  logic               drop;
  logic [N-HALF-1:0]  upper;
  logic               fmt_bad;

  // Handshake qualifiers; ready comes only from the registered level so a
  // pop in the same cycle never opens the input when full.
  always_comb begin
    in_ready  = (level_q != FULL_LVL);
    out_valid = (level_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    drop      = in_valid && !in_ready;
    upper     = in_data[N-1:HALF];
    fmt_bad   = (upper != '0) && (upper != '1);
  end

  // FIFO pointer and occupancy next-state; push and pop together keep level.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Status next-state; clr overrides any event arriving in the same cycle and
  // both counters stick at their maximum instead of wrapping.
  always_comb begin
    carry_cnt_d = carry_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    fmt_err_d   = fmt_err_q;
    if (clr) begin
      carry_cnt_d = '0;
      drop_cnt_d  = '0;
      fmt_err_d   = 1'b0;
    end else begin
      if (push && in_data[HALF] && (carry_cnt_q != '1)) begin
        carry_cnt_d = carry_cnt_q + CNT_W'(1);
      end
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      if (push && fmt_bad) begin
        fmt_err_d = 1'b1;
      end
    end
  end

  // Pointer, level and status registers; reset discards any in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      carry_cnt_q <= '0;
      drop_cnt_q  <= '0;
      fmt_err_q   <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      carry_cnt_q <= carry_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      fmt_err_q   <= fmt_err_d;
    end
  end

  // Storage array has no reset; a word is written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef RESULT_ACC_EN
  logic [ACC_W-1:0] acc_q, acc_d;

  // Accumulator next-state: unsigned (N/2+1)-bit sum of each accepted word, wrapping.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (push) begin
      acc_d = acc_q + ACC_W'(in_data[HALF:0]);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
`else
  assign acc = '0;
`endif

  assign out_data  = mem_q[rd_ptr_q];
  assign carry_cnt = carry_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign fmt_err   = fmt_err_q;
  assign level     = level_q;

endmodule

// File: tb/tb_adder_result_collector.sv
// Testbench for adder_result_collector: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model.
module tb_adder_result_collector;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  // Narrow counters so saturation is reachable in a few dozen cycles.
  localparam int CNT_W = 4;
  localparam int ACC_W = 24;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             inValid;
  logic [N-1:0]     inData;
  logic             inReady;
  logic             outValid;
  logic [N-1:0]     outData;
  logic             outReady;
  logic             clr;
  logic [CNT_W-1:0] carryCnt;
  logic [CNT_W-1:0] dropCnt;
  logic             fmtErr;
  logic [LVL_W-1:0] level;
  logic [ACC_W-1:0] acc;

  int nChecks = 0;
  int nFail   = 0;

  // Behavioural model state
  logic [N-1:0] modelQ[$];
  int           modelCarry;
  int           modelDrop;
  bit           modelFmt;
  longint       modelAcc;

  adder_result_collector #(
    .N(N), .DEPTH(DEPTH), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady), .out_valid(outValid), .out_data(outData),
    .out_ready(outReady), .clr(clr), .carry_cnt(carryCnt),
    .drop_cnt(dropCnt), .fmt_err(fmtErr), .level(level), .acc(acc)
  );

  always #5 clk = ~clk;

  // Expected accumulator value as seen on the port for this build
  function automatic longint expAcc();
`ifdef RESULT_ACC_EN
    return modelAcc;
`else
    return 0;
`endif
  endfunction

  // Update the model from the inputs now driven, then advance one clock
  task automatic applyStimulus();
    bit accept;
    bit doPop;
    int upperNib;
    if (rst) begin
      modelQ.delete();
      modelCarry = 0;
      modelDrop  = 0;
      modelFmt   = 1'b0;
      modelAcc   = 0;
    end else begin
      accept = inValid && (modelQ.size() < DEPTH);
      doPop  = outReady && (modelQ.size() > 0);
      if (doPop) void'(modelQ.pop_front());
      if (accept) modelQ.push_back(inData);
      if (clr) begin
        modelCarry = 0;
        modelDrop  = 0;
        modelFmt   = 1'b0;
        modelAcc   = 0;
      end else begin
        if (inValid && !accept && modelDrop < CNT_MAX) modelDrop++;
        if (accept) begin
          if (inData[N/2] && modelCarry < CNT_MAX) modelCarry++;
          upperNib = int'(inData) >> (N/2);
          if (upperNib != 0 && upperNib != (1 << (N/2)) - 1) modelFmt = 1'b1;
          modelAcc = (modelAcc + (int'(inData) % (1 << (N/2 + 1)))) % (64'd1 << ACC_W);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b1; inData = 8'hFF; outReady = 1'b0; clr = 1'b0;
    applyStimulus();
    applyStimulus();
    nChecks++; if (outValid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_out_valid got %0b want 0", outValid); end
    nChecks++; if (inReady !== 1'b1) begin nFail++; $display("[TB] FAIL reset_in_ready got %0b want 1", inReady); end
    nChecks++; if (level !== 0) begin nFail++; $display("[TB] FAIL reset_level got %0d want 0", level); end
    nChecks++; if (carryCnt !== 0) begin nFail++; $display("[TB] FAIL reset_carry_cnt got %0d want 0", carryCnt); end
    nChecks++; if (dropCnt !== 0) begin nFail++; $display("[TB] FAIL reset_drop_cnt got %0d want 0", dropCnt); end
    nChecks++; if (fmtErr !== 1'b0) begin nFail++; $display("[TB] FAIL reset_fmt_err got %0b want 0", fmtErr); end
    nChecks++; if (acc !== 0) begin nFail++; $display("[TB] FAIL reset_acc got %0d want 0", acc); end
    rst = 1'b0; inValid = 1'b0;
  endtask

  task automatic test_single_push();
    inValid = 1'b1; inData = 8'h05; outReady = 1'b0;
    applyStimulus();
    inValid = 1'b0;
    nChecks++; if (outValid !== 1'b1) begin nFail++; $display("[TB] FAIL single_out_valid got %0b want 1", outValid); end
    nChecks++; if (outData !== 8'h05) begin nFail++; $display("[TB] FAIL single_out_data got %h want 05", outData); end
    nChecks++; if (level !== 1) begin nFail++; $display("[TB] FAIL single_level got %0d want 1", level); end
    outReady = 1'b1;
    applyStimulus();
    outReady = 1'b0;
    nChecks++; if (outValid !== 1'b0) begin nFail++; $display("[TB] FAIL single_pop_valid got %0b want 0", outValid); end
    nChecks++; if (level !== 0) begin nFail++; $display("[TB] FAIL single_pop_level got %0d want 0", level); end
  endtask

  task automatic test_full_drop();
    outReady = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      inValid = 1'b1; inData = N'(i);
      applyStimulus();
    end
    nChecks++; if (inReady !== 1'b0) begin nFail++; $display("[TB] FAIL full_in_ready got %0b want 0", inReady); end
    nChecks++; if (level !== 4) begin nFail++; $display("[TB] FAIL full_level got %0d want 4", level); end
    inData = 8'h06;
    applyStimulus();
    inValid = 1'b0;
    nChecks++; if (dropCnt !== 1 || dropCnt !== modelDrop) begin nFail++; $display("[TB] FAIL full_drop_cnt got %0d want 1", dropCnt); end
    nChecks++; if (level !== 4) begin nFail++; $display("[TB] FAIL full_drop_level got %0d want 4", level); end
    outReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      nChecks++;
      if (outValid !== 1'b1 || outData !== N'(i)) begin
        nFail++; $display("[TB] FAIL drain_word%0d got valid=%0b data=%h want valid=1 data=%h", i, outValid, outData, N'(i));
      end
      applyStimulus();
    end
    outReady = 1'b0;
    nChecks++; if (outValid !== 1'b0) begin nFail++; $display("[TB] FAIL drain_empty got %0b want 0", outValid); end
  endtask

  task automatic test_carry_acc();
    clr = 1'b1;
    applyStimulus();
    clr = 1'b0;
    nChecks++; if (dropCnt !== 0) begin nFail++; $display("[TB] FAIL clr_drop_cnt got %0d want 0", dropCnt); end
    inValid = 1'b1; inData = 8'hF2;
    applyStimulus();
    inData = 8'h07;
    applyStimulus();
    inValid = 1'b0;
    nChecks++; if (carryCnt !== 1) begin nFail++; $display("[TB] FAIL carry_cnt got %0d want 1", carryCnt); end
    nChecks++; if (fmtErr !== 1'b0) begin nFail++; $display("[TB] FAIL carry_fmt_err got %0b want 0", fmtErr); end
`ifdef RESULT_ACC_EN
    nChecks++; if (acc !== 25) begin nFail++; $display("[TB] FAIL carry_acc got %0d want 25", acc); end
`else
    nChecks++; if (acc !== 0) begin nFail++; $display("[TB] FAIL carry_acc got %0d want 0", acc); end
`endif
    outReady = 1'b1;
    nChecks++; if (outData !== 8'hF2) begin nFail++; $display("[TB] FAIL carry_head0 got %h want f2", outData); end
    applyStimulus();
    nChecks++; if (outData !== 8'h07) begin nFail++; $display("[TB] FAIL carry_head1 got %h want 07", outData); end
    applyStimulus();
    outReady = 1'b0;
  endtask

  task automatic test_fmt_clr();
    inValid = 1'b1; inData = 8'h35;
    applyStimulus();
    inValid = 1'b0;
    nChecks++; if (fmtErr !== 1'b1) begin nFail++; $display("[TB] FAIL fmt_err_set got %0b want 1", fmtErr); end
    nChecks++; if (outData !== 8'h35 || level !== 1) begin nFail++; $display("[TB] FAIL fmt_stored got data=%h level=%0d want 35/1", outData, level); end
    clr = 1'b1; inValid = 1'b1; inData = 8'hF0;
    applyStimulus();
    clr = 1'b0; inValid = 1'b0;
    nChecks++; if (carryCnt !== 0) begin nFail++; $display("[TB] FAIL clr_carry got %0d want 0", carryCnt); end
    nChecks++; if (fmtErr !== 1'b0) begin nFail++; $display("[TB] FAIL clr_fmt got %0b want 0", fmtErr); end
    nChecks++; if (acc !== 0) begin nFail++; $display("[TB] FAIL clr_acc got %0d want 0", acc); end
    nChecks++; if (level !== 2) begin nFail++; $display("[TB] FAIL clr_level got %0d want 2", level); end
    outReady = 1'b1;
    nChecks++; if (outData !== 8'h35) begin nFail++; $display("[TB] FAIL clr_head0 got %h want 35", outData); end
    applyStimulus();
    nChecks++; if (outData !== 8'hF0) begin nFail++; $display("[TB] FAIL clr_head1 got %h want f0", outData); end
    applyStimulus();
    outReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    inValid = 1'b1; inData = 8'hA1;
    applyStimulus();
    inData = 8'hA2;
    applyStimulus();
    inData = 8'hA3; outReady = 1'b1;
    applyStimulus();
    nChecks++; if (level !== 2) begin nFail++; $display("[TB] FAIL b2b_level got %0d want 2", level); end
    nChecks++; if (outData !== 8'hA2) begin nFail++; $display("[TB] FAIL b2b_head got %h want a2", outData); end
    inData = 8'hA4; outReady = 1'b0;
    applyStimulus();
    nChecks++; if (level !== 3) begin nFail++; $display("[TB] FAIL b2b_level3 got %0d want 3", level); end
    rst = 1'b1; inValid = 1'b0;
    applyStimulus();
    rst = 1'b0;
    nChecks++; if (level !== 0 || outValid !== 1'b0 || inReady !== 1'b1) begin
      nFail++; $display("[TB] FAIL midrst_state got level=%0d valid=%0b ready=%0b want 0/0/1", level, outValid, inReady);
    end
    inValid = 1'b1; inData = 8'hB7;
    applyStimulus();
    inValid = 1'b0; outReady = 1'b1;
    nChecks++; if (outData !== 8'hB7 || level !== 1) begin nFail++; $display("[TB] FAIL midrst_fresh got data=%h level=%0d want b7/1", outData, level); end
    applyStimulus();
    outReady = 1'b0;
  endtask

  task automatic test_saturation();
    clr = 1'b1;
    applyStimulus();
    clr = 1'b0;
    inValid = 1'b1; outReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      inData = 8'hF0 | N'(i & 15);
      applyStimulus();
    end
    nChecks++; if (carryCnt !== CNT_W'(CNT_MAX) || carryCnt !== modelCarry) begin nFail++; $display("[TB] FAIL sat_carry got %0d want %0d", carryCnt, CNT_MAX); end
    outReady = 1'b0;
    for (int i = 0; i < 24; i++) applyStimulus();
    inValid = 1'b0;
    nChecks++; if (dropCnt !== CNT_W'(CNT_MAX) || dropCnt !== modelDrop) begin nFail++; $display("[TB] FAIL sat_drop got %0d want %0d", dropCnt, CNT_MAX); end
    nChecks++; if (inReady !== 1'b0) begin nFail++; $display("[TB] FAIL sat_in_ready got %0b want 0", inReady); end
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus();
    outReady = 1'b0;
    nChecks++; if (level !== 0) begin nFail++; $display("[TB] FAIL sat_drained got %0d want 0", level); end
  endtask

  task automatic test_random();
    int pick;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst      = ($urandom_range(0, 63) == 0);
      clr      = ($urandom_range(0, 15) == 0);
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 2) != 0);
      pick     = $urandom_range(0, 3);
      inData   = N'($urandom);
      if (pick == 0) inData[N-1:N/2] = '0;
      if (pick == 1) inData[N-1:N/2] = '1;
      applyStimulus();
      nChecks++;
      if (outValid !== (modelQ.size() > 0) || inReady !== (modelQ.size() < DEPTH) || level !== modelQ.size()) begin
        nFail++; $display("[TB] FAIL rand_fifo cyc=%0d got valid=%0b ready=%0b level=%0d want level=%0d", cyc, outValid, inReady, level, modelQ.size());
      end
      if (modelQ.size() > 0) begin
        nChecks++;
        if (outData !== modelQ[0]) begin nFail++; $display("[TB] FAIL rand_data cyc=%0d got %h want %h", cyc, outData, modelQ[0]); end
      end
      nChecks++;
      if (carryCnt !== modelCarry || dropCnt !== modelDrop || fmtErr !== modelFmt) begin
        nFail++; $display("[TB] FAIL rand_status cyc=%0d got c=%0d d=%0d f=%0b want c=%0d d=%0d f=%0b", cyc, carryCnt, dropCnt, fmtErr, modelCarry, modelDrop, modelFmt);
      end
      nChecks++;
      if (acc !== ACC_W'(expAcc())) begin nFail++; $display("[TB] FAIL rand_acc cyc=%0d got %0d want %0d", cyc, acc, expAcc()); end
    end
    rst = 1'b0; clr = 1'b0; inValid = 1'b0; outReady = 1'b0;
  endtask

  initial begin
    rst = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0; clr = 1'b0;
    modelCarry = 0; modelDrop = 0; modelFmt = 1'b0; modelAcc = 0;
    #2;
    test_reset();
    test_single_push();
    test_full_drop();
    test_carry_acc();
    test_fmt_clr();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
